// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
// No logic; constants only.
// No flow control of its own.
package rr_arb_mux_pkg;

   // Value presented on out_data while the output register is empty.
   localparam logic [31:0] MUX_IDLE_DATA = 32'h66666666;

   // Packet-lock FSM encoding, kept as plain constants for legacy tools.
   typedef logic mux_state_t;
   localparam mux_state_t ST_ARB  = 1'b0;
   localparam mux_state_t ST_LOCK = 1'b1;

   // Ceiling log2, returns at least 1 so a 2-channel index is 1 bit wide.
   function automatic int mux_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load.
module rr_arb_pick
   import rr_arb_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = mux_clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   // Walk the channels starting at ptr; the first requester found wins.
   always_comb begin
      int idx;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         // ptr is always < N, so a single subtraction handles the wrap.
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux into one registered output; optional
// packet lock under RR_ARB_MUX_LOCK_EN. Latency: 1 cycle accept -> out_valid, 1 beat/cycle.
// Backpressure: out_valid & ~out_ready holds out_* and the pointer, and zeroes in_ready.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter int          N         = 4,
   parameter int          SELW      = mux_clog2(N),
   parameter logic [31:0] IDLE_DATA = MUX_IDLE_DATA
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_ARB_MUX_LOCK_EN
   input  logic [N-1:0]       in_last,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan
);

   // Idle pattern sized to the data path (truncated or zero-extended).
   localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_DATA);
   localparam logic [SELW-1:0]  LAST_CHAN = SELW'(N - 1);

   logic [SELW-1:0] ptr;
   logic [N-1:0]    pick_req;
   logic            gnt_valid;
   logic [SELW-1:0] gnt_idx;
   logic            load;
   logic            accept;
   logic [SELW-1:0] ptr_next;

   // The output register can take a new beat when empty or being drained.
   assign load   = ~out_valid | out_ready;
   assign accept = load & gnt_valid & ~reset;

   // Pointer moves to the channel just after the winner, wrapping at N-1.
   assign ptr_next = (gnt_idx == LAST_CHAN) ? '0 : gnt_idx + 1'b1;

`ifdef RR_ARB_MUX_LOCK_EN
   mux_state_t      state;
   logic [SELW-1:0] lock_chan;

   // While a packet is open, only its channel is allowed to request.
   always_comb begin
      pick_req = in_valid;
      if (state == ST_LOCK)
         pick_req = in_valid & (N'(1) << lock_chan);
   end

   // Packet lock: open on a non-last beat, close on the last beat of lock_chan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_ARB;
         lock_chan <= '0;
      end else if (accept) begin
         if (state == ST_ARB) begin
            if (!in_last[gnt_idx]) begin
               state     <= ST_LOCK;
               lock_chan <= gnt_idx;
            end
         end else if (in_last[gnt_idx]) begin
            state <= ST_ARB;
         end
      end
   end
`else
   // Every beat is arbitrated on its own.
   always_comb begin
      pick_req = in_valid;
   end
`endif

   rr_arb_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_pick (
      .req       (pick_req),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // One-hot ready to the winning channel only when the register can load.
   always_comb begin
      in_ready = '0;
      if (accept)
         in_ready = N'(1) << gnt_idx;
   end

   // Priority pointer advances only on an accepted beat; frozen under stall.
   // Inside a lock the winner is lock_chan, so this lands on lock_chan+1.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (accept)
         ptr <= ptr_next;
   end

   // Output register: replace in place on load, empty to idle when no winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= IDLE_W;
         out_chan  <= '0;
      end else if (load) begin
         if (gnt_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_chan  <= gnt_idx;
         end else begin
            out_valid <= 1'b0;
            out_data  <= IDLE_W;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

   logic clk;
   logic reset;

   // 4-channel, 32-bit instance
   logic [3:0]     in_valid4;
   logic [3:0]     in_ready4;
   logic [127:0]   in_data4;
   logic           out_valid4;
   logic           out_ready4;
   logic [31:0]    out_data4;
   logic [1:0]     out_chan4;

   // 3-channel, 8-bit instance for wrap-around
   logic [2:0]     in_valid3;
   logic [2:0]     in_ready3;
   logic [23:0]    in_data3;
   logic           out_valid3;
   logic           out_ready3;
   logic [7:0]     out_data3;
   logic [1:0]     out_chan3;

`ifdef RR_ARB_MUX_LOCK_EN
   logic [3:0]     in_last4;
   logic [2:0]     in_last3;
`endif

   int checks;
   int failures;

   rr_arb_mux #(.WIDTH(32), .N(4)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
`ifdef RR_ARB_MUX_LOCK_EN
      .in_last   (in_last4),
`endif
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4),
      .out_chan  (out_chan4)
   );

   rr_arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .in_data   (in_data3),
`ifdef RR_ARB_MUX_LOCK_EN
      .in_last   (in_last3),
`endif
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_data  (out_data3),
      .out_chan  (out_chan3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset      = 1'b1;
      in_valid4  = 4'b1111;
      out_ready4 = 1'b1;
      in_valid3  = 3'b000;
      out_ready3 = 1'b1;
      for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'(i);
      for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'hA0 + 8'(i);
`ifdef RR_ARB_MUX_LOCK_EN
      in_last4 = 4'b1111;
      in_last3 = 3'b111;
`endif
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (in_ready4 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready cycle=%0d got=%b exp=%b", c, in_ready4, 4'b0000);
         end
      end
      checks++;
      if (out_valid4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid4);
      end
      checks++;
      if (out_data4 !== 32'h66666666) begin
         failures++;
         $display("FAIL reset_out_data got=%h exp=66666666", out_data4);
      end
      checks++;
      if (out_chan4 !== 2'd0) begin
         failures++;
         $display("FAIL reset_out_chan got=%0d exp=0", out_chan4);
      end
      checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 8'h66) begin
         failures++;
         $display("FAIL reset_n3 got valid=%b data=%h exp valid=0 data=66", out_valid3, out_data3);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready4 !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_grant got=%b exp=0001", in_ready4);
      end
   endtask

   task automatic test_fairness;
      int exp_chan [6];
      exp_chan = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (in_ready4 !== (4'b0001 << exp_chan[k])) begin
            failures++;
            $display("FAIL fair_in_ready beat=%0d got=%b exp_chan=%0d", k, in_ready4, exp_chan[k]);
         end
         tick();
         checks++;
         if (out_valid4 !== 1'b1 || out_chan4 !== 2'(exp_chan[k]) || out_data4 !== 32'(exp_chan[k])) begin
            failures++;
            $display("FAIL fair_out beat=%0d got valid=%b chan=%0d data=%h exp chan=%0d",
                     k, out_valid4, out_chan4, out_data4, exp_chan[k]);
         end
      end
   endtask

   task automatic test_backpressure;
      out_ready4 = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (in_ready4 !== 4'b0000) begin
            failures++;
            $display("FAIL bp_in_ready cycle=%0d got=%b exp=0000", c, in_ready4);
         end
         tick();
         checks++;
         if (out_valid4 !== 1'b1 || out_chan4 !== 2'd1 || out_data4 !== 32'd1) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got valid=%b chan=%0d data=%h exp valid=1 chan=1 data=1",
                     c, out_valid4, out_chan4, out_data4);
         end
      end
      out_ready4 = 1'b1;
      #1;
      checks++;
      if (in_ready4 !== 4'b0100) begin
         failures++;
         $display("FAIL bp_resume_ready got=%b exp=0100", in_ready4);
      end
      tick();
      checks++;
      if (out_chan4 !== 2'd2 || out_data4 !== 32'd2) begin
         failures++;
         $display("FAIL bp_resume_chan2 got chan=%0d data=%h exp 2", out_chan4, out_data4);
      end
      tick();
      checks++;
      if (out_chan4 !== 2'd3 || out_valid4 !== 1'b1) begin
         failures++;
         $display("FAIL bp_resume_chan3 got chan=%0d valid=%b exp 3", out_chan4, out_valid4);
      end
      in_valid4 = 4'b0000;
      #1;
      checks++;
      if (in_ready4 !== 4'b0000) begin
         failures++;
         $display("FAIL drain_in_ready got=%b exp=0000", in_ready4);
      end
      tick();
      checks++;
      if (out_valid4 !== 1'b0 || out_data4 !== 32'h66666666) begin
         failures++;
         $display("FAIL drain_idle got valid=%b data=%h exp valid=0 data=66666666", out_valid4, out_data4);
      end
   endtask

   task automatic test_sparse_wrap;
      in_valid3 = 3'b100;
      #1;
      checks++;
      if (in_ready3 !== 3'b100) begin
         failures++;
         $display("FAIL wrap_ready2 got=%b exp=100", in_ready3);
      end
      tick();
      checks++;
      if (out_valid3 !== 1'b1 || out_chan3 !== 2'd2 || out_data3 !== 8'hA2) begin
         failures++;
         $display("FAIL wrap_out2 got valid=%b chan=%0d data=%h exp chan=2 data=a2", out_valid3, out_chan3, out_data3);
      end
      // Pointer must have wrapped to 0: with all valid, channel 0 wins.
      in_valid3 = 3'b111;
      #1;
      checks++;
      if (in_ready3 !== 3'b001) begin
         failures++;
         $display("FAIL wrap_ptr0 got=%b exp=001", in_ready3);
      end
      tick();
      checks++;
      if (out_chan3 !== 2'd0 || out_data3 !== 8'hA0) begin
         failures++;
         $display("FAIL wrap_out0 got chan=%0d data=%h exp chan=0 data=a0", out_chan3, out_data3);
      end
      in_valid3 = 3'b001;
      #1;
      tick();
      checks++;
      if (out_valid3 !== 1'b1 || out_chan3 !== 2'd0 || out_data3 !== 8'hA0) begin
         failures++;
         $display("FAIL sparse_out0 got valid=%b chan=%0d data=%h exp chan=0", out_valid3, out_chan3, out_data3);
      end
      in_valid3 = 3'b000;
      #1;
      tick();
      checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 8'h66) begin
         failures++;
         $display("FAIL sparse_idle got valid=%b data=%h exp valid=0 data=66", out_valid3, out_data3);
      end
   endtask

   task automatic test_midstream_reset;
      in_valid4  = 4'b1111;
      out_ready4 = 1'b1;
      #1;
      checks++;
      if (in_ready4 !== 4'b0001) begin
         failures++;
         $display("FAIL mid_pre_ready got=%b exp=0001", in_ready4);
      end
      tick();
      tick();
      out_ready4 = 1'b0;
      #1;
      tick();
      checks++;
      if (out_valid4 !== 1'b1 || out_chan4 !== 2'd1) begin
         failures++;
         $display("FAIL mid_held got valid=%b chan=%0d exp valid=1 chan=1", out_valid4, out_chan4);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (out_valid4 !== 1'b0 || out_data4 !== 32'h66666666 || out_chan4 !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset got valid=%b data=%h chan=%0d exp valid=0 data=66666666 chan=0",
                  out_valid4, out_data4, out_chan4);
      end
      reset      = 1'b0;
      out_ready4 = 1'b1;
      #1;
      checks++;
      if (in_ready4 !== 4'b0001) begin
         failures++;
         $display("FAIL mid_ptr0 got=%b exp=0001", in_ready4);
      end
      tick();
      checks++;
      if (out_chan4 !== 2'd0 || out_data4 !== 32'd0) begin
         failures++;
         $display("FAIL mid_after got chan=%0d data=%h exp chan=0 data=0", out_chan4, out_data4);
      end
   endtask

`ifdef RR_ARB_MUX_LOCK_EN
   task automatic test_lock;
      int exp_ready [4];
      int exp_chan  [4];
      logic [3:0] last_seq [4];
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      out_ready4 = 1'b1;
      in_valid4  = 4'b0001;
      in_last4   = 4'b0001;
      #1;
      tick();
      checks++;
      if (out_chan4 !== 2'd0) begin
         failures++;
         $display("FAIL lock_setup got chan=%0d exp 0", out_chan4);
      end
      in_valid4 = 4'b0111;
      exp_ready = '{2, 2, 2, 4};
      exp_chan  = '{1, 1, 1, 2};
      last_seq  = '{4'b0000, 4'b0000, 4'b0010, 4'b0111};
      for (int k = 0; k < 4; k++) begin
         in_last4 = last_seq[k];
         #1;
         checks++;
         if (in_ready4 !== 4'(exp_ready[k])) begin
            failures++;
            $display("FAIL lock_ready beat=%0d got=%b exp=%b", k, in_ready4, 4'(exp_ready[k]));
         end
         tick();
         checks++;
         if (out_chan4 !== 2'(exp_chan[k]) || out_data4 !== 32'(exp_chan[k])) begin
            failures++;
            $display("FAIL lock_chan beat=%0d got chan=%0d data=%h exp chan=%0d", k, out_chan4, out_data4, exp_chan[k]);
         end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_fairness();
      test_backpressure();
      test_sparse_wrap();
      test_midstream_reset();
`ifdef RR_ARB_MUX_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
